// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and sizing for the sequential divider
//
// Purpose: FSM state encoding, operand width and iteration-counter width
//          shared by the divider top, its step unit and its bus interface.
// Ports:   none (package).

package divider_pkg;

  // Operand width: divisor/quotient/remainder are DIV_N bits, dividend 2*DIV_N.
  localparam int DIV_N = 64;

  // Counter must hold the value N itself, hence N+1 distinct values.
  localparam int CNT_W = $clog2(DIV_N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - operand/result handshake bundle for the divider
//
// Purpose: groups the input (operand) and output (result) valid/ready
//          channels of seq_divider.
// Ports:   master - operand source / result sink side
//          slave  - divider side
//          in_valid/in_ready/dividend/divisor : operand channel
//          out_valid/out_ready/quotient/remainder/div_by_zero/overflow : result

interface seq_divider_if #(
  parameter int N = divider_pkg::DIV_N
);

  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division step
//
// Purpose: shifts the next dividend bit into the partial remainder and
//          subtracts the divisor when it fits.
// Ports:   r_in    in  N+1  partial remainder (always < divisor)
//          bit_in  in  1    next dividend bit, MSB first
//          divisor in  N    divisor
//          r_out   out N+1  updated partial remainder
//          q_bit   out 1    quotient bit produced by this step

module div_step
  import divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   r_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_out,
  output logic         q_bit
);

  // Two bits of headroom: the shifted remainder needs N+1 bits and the sign
  // of the trial subtraction lands in the extra top bit, so the compare is
  // never truncated.
  logic [N+1:0] t;
  logic [N+1:0] diff;

  assign t     = {r_in, bit_in};
  assign diff  = t - {2'b00, divisor};
  assign q_bit = ~diff[N+1];
  assign r_out = q_bit ? diff[N:0] : t[N:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative 2N-by-N unsigned divider, one quotient bit per clock
//
// Purpose: restoring division of a 2N-bit dividend by an N-bit divisor with
//          valid/ready handshakes; zero divisor and quotient overflow are
//          detected up front and answered in one cycle.
// Ports:   clk    in  1   rising-edge clock
//          rst_n  in  1   asynchronous active-low reset
//          bus    slave   operand/result channels (see seq_divider_if)

module seq_divider
  import divider_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int N = DIV_N;

  div_state_e      state_q, state_d;
  logic [N:0]      r_q;
  logic [N-1:0]    q_q;
  logic [N-1:0]    dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic            dz_q;
  logic            ov_q;

  logic            dz_in;
  logic            ov_in;
  logic [N:0]      r_step;
  logic            bit_step;

  // Classification of the offered operands; only acted on in IDLE.
  assign dz_in = (bus.divisor == '0);
  assign ov_in = !dz_in && (bus.dividend[2*N-1:N] >= bus.divisor);

  // Q doubles as the dividend low-half shifter: its MSB feeds the step while
  // quotient bits enter at the LSB.
  div_step #(.N(N)) u_step (
    .r_in    (r_q),
    .bit_in  (q_q[N-1]),
    .divisor (dvs_q),
    .r_out   (r_step),
    .q_bit   (bit_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = (dz_in || ov_in) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            dvs_q <= bus.divisor;
            if (dz_in) begin
              q_q   <= '1;
              r_q   <= {1'b0, bus.dividend[N-1:0]};
              cnt_q <= '0;
              dz_q  <= 1'b1;
              ov_q  <= 1'b0;
            end else if (ov_in) begin
              q_q   <= '1;
              r_q   <= '0;
              cnt_q <= '0;
              dz_q  <= 1'b0;
              ov_q  <= 1'b1;
            end else begin
              q_q   <= bus.dividend[N-1:0];
              r_q   <= {1'b0, bus.dividend[2*N-1:N]};
              cnt_q <= CNT_W'(N);
              dz_q  <= 1'b0;
              ov_q  <= 1'b0;
            end
          end
        end
        BUSY: begin
          r_q   <= r_step;
          q_q   <= {q_q[N-2:0], bit_step};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers are the working registers; they are only meaningful
  // while out_valid is high and hold still in DONE.
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q[N-1:0];
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ov_q;

endmodule
